// File: rtl/voice_mixer.sv
// Time-multiplexed N-voice mixer. A SampleReq snapshots every voice, one voice
// per cycle is scaled by its gain and accumulated, and the sum is reduced to
// WAVE_DEPTH bits (divide-down or clamp) and presented with a one-cycle Valid.
module voice_mixer #(
  parameter int WAVE_DEPTH = 8,
  parameter int NUM_VOICES = 4,
  parameter int GAIN_DEPTH = 4,
  parameter int SATURATE   = 0,
  localparam int VB        = $clog2(NUM_VOICES)
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             SampleReq,
  input  logic [NUM_VOICES*WAVE_DEPTH-1:0] VoiceSamples,
  input  logic [NUM_VOICES-1:0]            MuteMask,
  input  logic                             GainWrite,
  input  logic [VB-1:0]                    GainSel,
  input  logic [GAIN_DEPTH-1:0]            GainData,
  output logic [WAVE_DEPTH-1:0]            Mixed,
  output logic                             Valid,
  output logic                             Clip,
  output logic                             Overrun,
  output logic                             Busy
);

  localparam int PW = WAVE_DEPTH + GAIN_DEPTH;
  localparam int AW = WAVE_DEPTH + GAIN_DEPTH + VB;
  localparam logic [GAIN_DEPTH-1:0] GAIN_UNITY = GAIN_DEPTH'(2 ** (GAIN_DEPTH - 1));
  localparam logic [AW-1:0]         WAVE_MAX   = AW'((2 ** WAVE_DEPTH) - 1);
  localparam logic [VB-1:0]         LAST_IDX   = VB'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUTPUT
  } state_e;

  state_e                                   state_q, state_d;
  logic [VB-1:0]                            idx_q, idx_d;
  logic [AW-1:0]                            acc_q, acc_d;
  logic [NUM_VOICES-1:0][WAVE_DEPTH-1:0]    samples_q, samples_d;
  logic [NUM_VOICES-1:0]                    mute_q, mute_d;
  logic [NUM_VOICES-1:0][GAIN_DEPTH-1:0]    gain_q, gain_d;
  logic [WAVE_DEPTH-1:0]                    mixed_q, mixed_d;
  logic                                     valid_q, valid_d;
  logic                                     clip_q, clip_d;
  logic                                     overrun_q, overrun_d;

  logic [PW-1:0]         contrib;
  logic [AW-1:0]         scaled;
  logic [WAVE_DEPTH-1:0] mixed_next;
  logic                  clip_next;

  // Gain register file: a write lands on the next edge, so the accumulator
  // always sees the value held before any same-cycle write.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first;
    // every path then drives every output, so no latch can be inferred.
    gain_d = gain_q;
    if (GainWrite) gain_d[GainSel] = GainData;
  end

  // Weighted contribution of the voice selected by the accumulation index.
  always_comb begin
    contrib = '0;
    if (!mute_q[idx_q]) contrib = PW'(samples_q[idx_q]) * PW'(gain_q[idx_q]);
  end

  // Reduce the final sum to an output sample: divide-down or clamp.
  always_comb begin
    scaled     = '0;
    mixed_next = '0;
    clip_next  = 1'b0;
    if (SATURATE != 0) begin
      scaled = acc_q >> (GAIN_DEPTH - 1);
      if (scaled > WAVE_MAX) begin
        mixed_next = '1;
        clip_next  = 1'b1;
      end else begin
        mixed_next = scaled[WAVE_DEPTH-1:0];
      end
    end else begin
      scaled     = acc_q >> (GAIN_DEPTH - 1 + VB);
      mixed_next = scaled[WAVE_DEPTH-1:0];
    end
  end

  // Frame sequencer: accept, accumulate one voice per cycle, then publish.
  always_comb begin
    logic accept;
    accept    = 1'b0;
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    samples_d = samples_q;
    mute_d    = mute_q;
    mixed_d   = mixed_q;
    clip_d    = clip_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = SampleReq;
      end
      ST_ACCUM: begin
        acc_d     = acc_q + AW'(contrib);
        idx_d     = idx_q + VB'(1);
        overrun_d = SampleReq;
        if (idx_q == LAST_IDX) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        valid_d = 1'b1;
        mixed_d = mixed_next;
        clip_d  = clip_next;
        state_d = ST_IDLE;
        accept  = SampleReq;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      samples_d = VoiceSamples;
      mute_d    = MuteMask;
      acc_d     = '0;
      idx_d     = '0;
      state_d   = ST_ACCUM;
    end
  end

  // Control, result and gain registers with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // the pre-edge values regardless of statement order.
    if (Reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      gain_q    <= {NUM_VOICES{GAIN_UNITY}};
      mixed_q   <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      gain_q    <= gain_d;
      mixed_q   <= mixed_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  // Frame snapshot of samples and mutes.
  always_ff @(posedge Clock) begin
    // NOTE: the snapshot is left without reset; it is always reloaded on
    // accept before it is read, so a reset would only cost routing.
    samples_q <= samples_d;
    mute_q    <= mute_d;
  end

  assign Mixed   = mixed_q;
  assign Valid   = valid_q;
  assign Clip    = clip_q;
  assign Overrun = overrun_q;
  assign Busy    = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: one divide-down and one saturating instance share the
// same stimulus; a frame-level reference model feeds a scoreboard that a
// negedge monitor drains whenever Valid is presented.
module tb_voice_mixer;

  localparam int NV = 4;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] samples;
  logic [3:0]  mute;
  logic        gw;
  logic [1:0]  gsel;
  logic [3:0]  gdata;

  logic [7:0] mixed0, mixed1;
  logic       valid0, valid1, clip0, clip1, ovr0, ovr1, busy0, busy1;

  voice_mixer #(.WAVE_DEPTH(8), .NUM_VOICES(NV), .GAIN_DEPTH(4), .SATURATE(0)) dut_div (
    .Clock(clk), .Reset(rst), .SampleReq(req), .VoiceSamples(samples), .MuteMask(mute),
    .GainWrite(gw), .GainSel(gsel), .GainData(gdata),
    .Mixed(mixed0), .Valid(valid0), .Clip(clip0), .Overrun(ovr0), .Busy(busy0)
  );

  voice_mixer #(.WAVE_DEPTH(8), .NUM_VOICES(NV), .GAIN_DEPTH(4), .SATURATE(1)) dut_sat (
    .Clock(clk), .Reset(rst), .SampleReq(req), .VoiceSamples(samples), .MuteMask(mute),
    .GainWrite(gw), .GainSel(gsel), .GainData(gdata),
    .Mixed(mixed1), .Valid(valid1), .Clip(clip1), .Overrun(ovr1), .Busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [7:0] m0;
    logic       c0;
    logic [7:0] m1;
    logic       c1;
  } exp_t;

  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model state (frame level).
  bit         frame_active = 1'b0;
  int         acc_edge     = 0;
  logic [7:0] f_samp[NV];
  logic [3:0] f_mute;
  int         used_gain[NV];
  int         gain_model[NV];
  bit         exp_ovr  = 1'b0;
  bit         exp_busy = 1'b0;
  logic [7:0] hold_m0 = '0, hold_m1 = '0;
  logic       hold_c0 = 1'b0, hold_c1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Mixed value for a completed frame from plain arithmetic.
  task automatic push_expected(input int e);
    exp_t x;
    int   sum;
    int   v;
    sum = 0;
    for (int i = 0; i < NV; i++)
      if (!f_mute[i]) sum += int'(f_samp[i]) * used_gain[i];
    x.edge_no = e;
    x.m0      = 8'((sum >> 5) & 255);
    x.c0      = 1'b0;
    v         = sum >> 3;
    x.c1      = (v > 255);
    x.m1      = x.c1 ? 8'hFF : 8'(v);
    exp_q.push_back(x);
  endtask

  // Apply the current inputs at the next rising edge and advance the model.
  task automatic tick();
    int e;
    bit in_accum;
    bit nxt_ovr;
    bit nxt_busy;
    e       = cyc + 1;
    nxt_ovr = 1'b0;
    if (rst) begin
      frame_active = 1'b0;
      for (int i = 0; i < NV; i++) gain_model[i] = 8;
    end else begin
      in_accum = frame_active && (e >= acc_edge + 1) && (e <= acc_edge + NV);
      if (in_accum) used_gain[e-acc_edge-1] = gain_model[e-acc_edge-1];
      if (frame_active && e == acc_edge + NV + 1) begin
        push_expected(e);
        frame_active = 1'b0;
      end
      nxt_ovr = req && in_accum;
      if (req && !in_accum) begin
        frame_active = 1'b1;
        acc_edge     = e;
        for (int i = 0; i < NV; i++) f_samp[i] = samples[i*8 +: 8];
        f_mute = mute;
      end
      if (gw) gain_model[gsel] = int'(gdata);
    end
    nxt_busy = frame_active && (e >= acc_edge) && (e <= acc_edge + NV - 1);
    @(posedge clk);
    cyc      = e;
    exp_ovr  = nxt_ovr;
    exp_busy = nxt_busy;
    if (rst) begin
      hold_m0 = '0; hold_m1 = '0; hold_c0 = 1'b0; hold_c1 = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; gw = 1'b0; rst = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] s, input logic [3:0] m);
    samples = s; mute = m; req = 1'b1; gw = 1'b0; rst = 1'b0;
    tick();
    req = 1'b0;
  endtask

  task automatic wgain(input logic [1:0] sel, input logic [3:0] data);
    gw = 1'b1; gsel = sel; gdata = data; req = 1'b0; rst = 1'b0;
    tick();
    gw = 1'b0;
  endtask

  // Scoreboard monitor: pop on Valid, otherwise demand silence and held outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].edge_no == cyc) begin
        check("valid_div", 32'(valid0), 32'd1);
        check("valid_sat", 32'(valid1), 32'd1);
        hold_m0 = exp_q[0].m0; hold_c0 = exp_q[0].c0;
        hold_m1 = exp_q[0].m1; hold_c1 = exp_q[0].c1;
        void'(exp_q.pop_front());
      end else begin
        check("no_valid_div", 32'(valid0), 32'd0);
        check("no_valid_sat", 32'(valid1), 32'd0);
      end
      check("mixed_div", 32'(mixed0), 32'(hold_m0));
      check("mixed_sat", 32'(mixed1), 32'(hold_m1));
      check("clip_div", 32'(clip0), 32'(hold_c0));
      check("clip_sat", 32'(clip1), 32'(hold_c1));
      check("overrun_div", 32'(ovr0), 32'(exp_ovr));
      check("overrun_sat", 32'(ovr1), 32'(exp_ovr));
      check("busy_div", 32'(busy0), 32'(exp_busy));
      check("busy_sat", 32'(busy1), 32'(exp_busy));
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; gw = 1'b0; gsel = '0; gdata = '0;
    samples = '0; mute = '0;
    for (int i = 0; i < NV; i++) gain_model[i] = 8;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Unity-gain readback and basic sums.
    send({4{8'h10}}, 4'b0000); idle(6);
    send({4{8'h40}}, 4'b0000); idle(6);
    send({4{8'h80}}, 4'b1010); idle(6);

    // Single hot voice at maximum gain.
    wgain(2'd0, 4'd15); wgain(2'd1, 4'd0); wgain(2'd2, 4'd0); wgain(2'd3, 4'd0);
    send(32'h0000_00FF, 4'b0000); idle(6);
    for (int i = 0; i < NV; i++) wgain(2'(i), 4'd8);

    // Dropped request in ACCUM, then back-to-back request in OUTPUT.
    send(32'h1122_3344, 4'b0000);
    idle(1);
    send(32'hFFFF_FFFF, 4'b0000);
    idle(2);
    send(32'h0A0B_0C0D, 4'b0001);
    idle(6);

    // Reset two cycles into a frame aborts it and restores unity gains.
    wgain(2'd1, 4'd3);
    send(32'h5555_5555, 4'b0000);
    idle(1);
    rst = 1'b1; tick(); rst = 1'b0;
    idle(3);
    send({4{8'h10}}, 4'b0000); idle(6);

    // Randomized traffic including mid-frame gain writes and resets.
    repeat (300) begin
      req     = ($urandom_range(2) == 0);
      samples = $urandom;
      mute    = 4'($urandom);
      gw      = ($urandom_range(3) == 0);
      gsel    = 2'($urandom);
      gdata   = 4'($urandom);
      rst     = ($urandom_range(59) == 0);
      tick();
    end
    idle(8);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
